muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO registers. It sits beside the execute-stage ALU. Execute hands it operands when decode emits MULT_OP or DIV_OP. It interlocks MFHI/MFLO, and any back-to-back MULT/DIV, with a stall until the result is written. It performs one iterative shift-add or restoring-subtract step per clock, followed by a sign-fix cycle.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITERS, XLEN, iteration cycles per operation.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- start  input  1  execute presents a MULT/DIV this cycle.
- op_div  input  1  0 = multiply, 1 = divide.
- op_signed  input  1  1 = MULT/DIV, 0 = MULTU/DIVU.
- rs_val  input  XLEN  multiplicand / dividend.
- rt_val  input  XLEN  multiplier / divisor.
- flush  input  1  squash of the in-flight operation (branch/jump kill).
- rd_req  input  1  MFHI/MFLO in execute this cycle.
- rd_hi  input  1  1 = MFHI, 0 = MFLO.
- rd_data  output  XLEN  HI or LO; combinational from the registers.
- stall  output  1  pipeline must hold execute and all earlier stages.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse after HI/LO are written.
- div_zero  output  1  sticky flag: the last divide had rt_val == 0.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset values: state IDLE; hi, lo, busy, done, div_zero, stall = 0; iteration counter = 0.
- Reset mid-operation aborts the operation and clears HI/LO.
- States:
  - IDLE: start=1 captures the operand magnitudes, op and signs; counter = 0; go to RUN.
  - RUN: one step per cycle; when counter == ITERS-1, go to FIX; otherwise counter += 1.
  - FIX: apply sign correction, write hi/lo, done = 1 in the following cycle, go to IDLE.
- Latency: start accepted at edge E0; RUN spans E1..E32; FIX writes HI/LO at E33. busy = 1 from after E0 until after E33, so the result is readable in the cycle after E33.
- Magnitudes: when op_signed = 1, take the two's-complement absolute value. |0x80000000| is treated as unsigned 0x80000000.
- Multiply: 2*XLEN-bit accumulator; shift-add on the LSB of the multiplier each step. In FIX, negate the 64-bit product if the operand signs differ; then {hi, lo} = product.
- Divide: restoring algorithm with an XLEN+1-bit partial remainder. In FIX:
  - Quotient is negated if the signs differ (signed only).
  - Remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero:
  - Detected at start; the operation still takes the full latency.
  - Result: lo = 0xFFFFFFFF, hi = rs_val (original, unsigned view).
  - div_zero = 1, held until the next accepted start.
- stall = (busy & start) | (busy & rd_req). The requester holds start/rd_req and its operands until stall = 0. start while busy is not accepted.
- rd_req in IDLE never stalls; rd_data = rd_hi ? hi : lo in the same cycle.
- Simultaneous rd_req and start in IDLE: the read returns the pre-operation HI/LO, and the start is accepted.
- Cycle of E33 (FIX): busy still 1, so a pending read stalls one more cycle and then sees the new value. No write-to-read bypass.
- flush while busy: return to IDLE next edge; hi, lo and div_zero unchanged; no done pulse.
- flush with start in IDLE: start is ignored.
- flush has no effect on rd_req.

Decomposition:
- Shared package mdu_pkg holds:
  - state encoding IDLE/RUN/FIX;
  - OP_MUL/OP_DIV constants;
  - ITERS default;
  - DIV0_LO = 0xFFFFFFFF.
- One sub-module, mdu_step: combinational single iteration. Inputs: op, accumulator/remainder, operand. Outputs: next accumulator/remainder and quotient bit.
- FSM, counter, sign fix and HI/LO live in muldiv_hilo_ctrl.

Test Plan:
- MULT signed, rs=7, rt=0xFFFFFFFD (-3) -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. The same operands signed -> hi=0, lo=1.
- DIV signed rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1; the next start with rt=1 clears div_zero.
- MFHI issued 1 cycle after start -> stall=1 for exactly 33 cycles; rd_data then equals the new hi. A second start issued while busy -> stall until IDLE, then accepted.
- flush at RUN cycle 10 -> IDLE next cycle, hi/lo keep their prior values, no done. reset at RUN cycle 10 -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared constants for the MULT/DIV sequencer and its
//                single-iteration step unit: FSM state encoding, operation
//                encoding, default iteration count and the divide-by-zero
//                LO value.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // Sequencer state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    // Operation select (matches the op_div input)
    localparam logic c_OP_MUL = 1'b0;
    localparam logic c_OP_DIV = 1'b1;

    // One iteration per operand bit
    localparam int c_ITERS = 32;

    // LO result of a divide by zero
    localparam logic [31:0] c_DIV0_LO = 32'hFFFF_FFFF;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_step
//  Description : Combinational single iteration of the multiply/divide loop.
//                Multiply : i_acc = {partial product, remaining multiplier};
//                           add the multiplicand when the multiplier LSB is
//                           set, then shift the whole accumulator right.
//                Divide   : i_acc = {partial remainder, remaining dividend};
//                           shift one dividend bit into the remainder and
//                           subtract the divisor if it fits (restoring).
//  Ports       : i_op      - c_OP_MUL / c_OP_DIV
//                i_acc     - accumulator (multiply) / remainder+dividend
//                i_operand - multiplicand (multiply) / divisor (divide)
//                o_acc     - next accumulator; for divide bit 0 is left at 0
//                o_qbit    - quotient bit for bit 0 of o_acc (0 for multiply)
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              i_op,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_operand,
    output logic [2*XLEN-1:0] o_acc,
    output logic              o_qbit
);

    logic [XLEN:0]   w_sum;      // partial product plus carry
    logic [XLEN:0]   w_shifted;  // XLEN+1-bit partial remainder after shift-in
    logic            w_fits;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_new_rem;

    always_comb begin
        w_sum     = {1'b0, i_acc[2*XLEN-1:XLEN]}
                  + {1'b0, (i_acc[0] ? i_operand : {XLEN{1'b0}})};
        w_shifted = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
        w_fits    = (w_shifted >= {1'b0, i_operand});
        // When the divisor fits, the difference is below the divisor and
        // therefore always representable in XLEN bits.
        w_diff    = w_shifted[XLEN-1:0] - i_operand;
        w_new_rem = w_fits ? w_diff : w_shifted[XLEN-1:0];

        if (i_op == c_OP_DIV) begin
            o_acc  = {w_new_rem, i_acc[XLEN-2:0], 1'b0};
            o_qbit = w_fits;
        end else begin
            o_acc  = {w_sum, i_acc[XLEN-1:1]};
            o_qbit = 1'b0;
        end
    end

endmodule : mdu_step
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_hilo_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the
//                architectural HI/LO registers. One shift-add / restoring-
//                subtract step per clock for ITERS cycles, then a sign-fix
//                cycle that writes HI/LO. Interlocks MFHI/MFLO and
//                back-to-back MULT/DIV with a stall while busy.
//  Ports       : clock, reset          - clock, synchronous active-high reset
//                start, op_div,
//                op_signed, rs_val,
//                rt_val                - operation request and operands
//                flush                 - squash in-flight operation
//                rd_req, rd_hi         - MFHI/MFLO request, rd_data result
//                stall, busy, done     - pipeline interlock / status
//                div_zero              - sticky divide-by-zero flag
//                hi, lo                - architectural HI/LO registers
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_hilo_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            op_div,
    input  logic            op_signed,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    input  logic            rd_req,
    input  logic            rd_hi,
    output logic [XLEN-1:0] rd_data,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int              c_CNT_W    = $clog2(ITERS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ITERS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_operand;
    logic               r_op;
    logic               r_neg_q;     // product / quotient must be negated
    logic               r_neg_r;     // remainder takes a negative sign
    logic               r_div0;      // divide with zero divisor in flight
    logic [XLEN-1:0]    r_rs_orig;   // original dividend for divide by zero
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic               r_done;
    logic               r_div_zero;

    // ------------------------------------------------------------------
    // Operand capture: two's-complement magnitudes. The most negative
    // value negates to itself, which read unsigned is the right magnitude.
    // ------------------------------------------------------------------
    logic            w_rs_neg;
    logic            w_rt_neg;
    logic [XLEN-1:0] w_rs_mag;
    logic [XLEN-1:0] w_rt_mag;
    logic            w_accept;

    assign w_rs_neg = op_signed & rs_val[XLEN-1];
    assign w_rt_neg = op_signed & rt_val[XLEN-1];
    assign w_rs_mag = w_rs_neg ? (-rs_val) : rs_val;
    assign w_rt_mag = w_rt_neg ? (-rt_val) : rt_val;
    assign w_accept = (r_state == c_IDLE) & start & ~flush;

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_step_acc;
    logic              w_step_qbit;

    mdu_step #(
        .XLEN      (XLEN)
    ) u_step (
        .i_op      (r_op),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc),
        .o_qbit    (w_step_qbit)
    );

    // ------------------------------------------------------------------
    // Sign fix
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_hi;
    logic [XLEN-1:0]   w_fix_lo;

    always_comb begin
        w_prod = r_neg_q ? (-r_acc) : r_acc;
        w_quo  = r_neg_q ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_rem  = r_neg_r ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
        if (r_op == c_OP_MUL) begin
            w_fix_hi = w_prod[2*XLEN-1:XLEN];
            w_fix_lo = w_prod[XLEN-1:0];
        end else if (r_div0) begin
            w_fix_hi = r_rs_orig;
            w_fix_lo = XLEN'(c_DIV0_LO);
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_state_nxt = c_RUN;
            c_RUN: begin
                if (flush)                    w_state_nxt = c_IDLE;
                else if (r_cnt == c_CNT_LAST) w_state_nxt = c_FIX;
            end
            c_FIX:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (r_state != c_IDLE);
        stall   = busy & (start | rd_req);
        // Read is straight from the registers: no bypass of the FIX write.
        rd_data = rd_hi ? r_hi : r_lo;
    end

    // ------------------------------------------------------------------
    // Datapath, counter and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_op       <= c_OP_MUL;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_rs_orig  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_op       <= op_div;
                        r_neg_q    <= w_rs_neg ^ w_rt_neg;
                        r_neg_r    <= w_rs_neg;
                        r_div0     <= op_div & (rt_val == '0);
                        r_rs_orig  <= rs_val;
                        r_div_zero <= 1'b0;
                        // Multiply iterates over the multiplier in the low
                        // half; divide shifts the dividend out of it.
                        r_acc      <= {{XLEN{1'b0}}, (op_div ? w_rs_mag : w_rt_mag)};
                        r_operand  <= op_div ? w_rt_mag : w_rs_mag;
                    end
                end
                c_RUN: begin
                    if (!flush) begin
                        // Quotient bit drops into the slot the step left free.
                        r_acc <= {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_step_qbit};
                        if (r_cnt != c_CNT_LAST) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_FIX: begin
                    if (!flush) begin
                        r_hi       <= w_fix_hi;
                        r_lo       <= w_fix_lo;
                        r_done     <= 1'b1;
                        r_div_zero <= r_div0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule : muldiv_hilo_ctrl
`default_nettype wire

// File: tb/tb_muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_hilo_ctrl
//  Description : Scoreboard bench for muldiv_hilo_ctrl. Stimulus pushes the
//                hand-computed HI/LO/div_zero of each accepted operation;
//                a monitor pops and compares on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_hilo_ctrl;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_hi = 1'b0;
    logic [31:0] rd_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   pushed = 0;

    muldiv_hilo_ctrl #(
        .XLEN      (32),
        .ITERS     (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op_div    (op_div),
        .op_signed (op_signed),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .rd_req    (rd_req),
        .rd_hi     (rd_hi),
        .rd_data   (rd_data),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clock) begin
        if (!reset && done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_div_zero", {31'b0, div_zero}, {31'b0, e.dz});
            end
        end
    end

    // Present an operation and hold it until accepted (busy low before edge)
    task automatic issue(input logic d, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic push,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, output int waited, output logic sok);
        waited = 0;
        sok    = 1'b1;
        @(negedge clock);
        start = 1'b1; op_div = d; op_signed = s; rs_val = a; rt_val = b;
        #1;
        while (busy === 1'b1 && waited < 200) begin
            if (stall !== 1'b1) sok = 1'b0;
            @(negedge clock);
            #1;
            waited++;
        end
        if (busy !== 1'b0) chk("issue_timeout", {31'b0, busy}, 32'd0);
        if (push) begin
            sb_q.push_back('{hi: eh, lo: el, dz: edz});
            pushed++;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((sb_q.size() != 0 || busy === 1'b1) && n < 300);
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
    endtask

    task automatic op(input logic d, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eh,
                      input logic [31:0] el, input logic edz);
        int   w;
        logic sk;
        issue(d, s, a, b, 1'b1, eh, el, edz, w, sk);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   n;
        logic sk;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        // Multiply / divide result vectors
        op(1'b0, 1'b1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0);
        op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        op(1'b1, 1'b0, 32'd7,        32'd2,         32'd1,         32'd3,         1'b0);
        op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
        op(1'b1, 1'b0, 32'h1234,     32'h0,         32'h1234,      32'hFFFF_FFFF, 1'b1);
        op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        op(1'b1, 1'b0, 32'd5,        32'd1,         32'd0,         32'd5,         1'b0);

        // MFHI/MFLO in IDLE: no stall, same-cycle data
        @(negedge clock);
        rd_req = 1'b1; rd_hi = 1'b1;
        #1;
        chk("idle_mfhi", rd_data, 32'h0);
        chk("idle_rd_stall", {31'b0, stall}, 32'd0);
        rd_hi = 1'b0;
        #1;
        chk("idle_mflo", rd_data, 32'd5);
        rd_req = 1'b0;

        // Read and start together in IDLE: old value read, start accepted
        @(negedge clock);
        start = 1'b1; op_div = 1'b0; op_signed = 1'b0;
        rs_val = 32'h1_0000; rt_val = 32'h1_0000;
        rd_req = 1'b1; rd_hi = 1'b0;
        #1;
        chk("rd_start_data", rd_data, 32'd5);
        chk("rd_start_stall", {31'b0, stall}, 32'd0);
        sb_q.push_back('{hi: 32'h1, lo: 32'h0, dz: 1'b0});
        pushed++;
        @(posedge clock);
        #1;
        start = 1'b0; rd_req = 1'b0;
        chk("rd_start_accepted", {31'b0, busy}, 32'd1);
        wait_done();

        // MFHI one cycle after start stalls until HI/LO are written
        issue(1'b0, 1'b0, 32'h2_0000, 32'h1_0000, 1'b1, 32'h2, 32'h0, 1'b0, w, sk);
        rd_req = 1'b1; rd_hi = 1'b1;
        n = 0;
        @(negedge clock);
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("mfhi_stall_cycles", n, 32'd33);
        chk("mfhi_rd_data", rd_data, 32'h2);
        rd_req = 1'b0;
        wait_done();

        // Back-to-back MULT then DIVU: second start stalls until IDLE
        issue(1'b0, 1'b1, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6, 1'b0, w, sk);
        issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, w, sk);
        chk("b2b_wait_cycles", w, 32'd33);
        chk("b2b_stall_held", {31'b0, sk}, 32'd1);
        wait_done();

        // Flush at RUN cycle 10: no write, no done
        issue(1'b0, 1'b0, 32'd3, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0, w, sk);
        repeat (10) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_hi", hi, 32'd2);
        chk("flush_lo", lo, 32'd14);
        repeat (40) @(negedge clock);
        chk("flush_hi_later", hi, 32'd2);
        chk("flush_lo_later", lo, 32'd14);
        chk("flush_div_zero", {31'b0, div_zero}, 32'd0);

        // Flush together with start in IDLE: start ignored
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op_div = 1'b0; rs_val = 32'd9; rt_val = 32'd9;
        @(posedge clock);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_ignored", {31'b0, busy}, 32'd0);

        // Reset at RUN cycle 10: aborts and clears HI/LO
        issue(1'b0, 1'b0, 32'd4, 32'd4, 1'b0, 32'h0, 32'h0, 1'b0, w, sk);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clock);

        chk("done_count", done_seen, pushed);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_hilo_ctrl
`default_nettype wire
